// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE W-side datapath.
package redmule_pkg;

    localparam int unsigned ARRAY_HEIGHT   = 12;
    localparam int unsigned GROUP_ID_WIDTH = 16;
    localparam int unsigned W_LOADER_CNT_W = 16;

    // Pass-level state of the W loader.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } w_loader_state_e;

    // Start command with the pass configuration sampled alongside it.
    typedef struct packed {
        logic                      start;
        logic [W_LOADER_CNT_W-1:0] k_rows;
        logic [3:0]                gsize_log2;
        logic                      dequant;
    } w_loader_ctrl_t;

endpackage

// File: rtl/redmule_w_loader_fifo.sv
// Small skid FIFO between the W stream and the W-buffer load port.
// The pointers carry one extra wrap bit so full and empty can be told apart.
module redmule_w_loader_fifo #(
    parameter int unsigned DW         = 288,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic          w_doPush;
    logic          w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr[AW-1:0]];

    // Advance the pointers; a flush empties the FIFO without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
        end
    end

    // Storage needs no reset: it is only visible through the pointers.
    always_ff @(posedge clk_i) begin
        if (w_doPush && !i_flush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/redmule_w_loader.sv
// W-buffer feeder: buffers streamed W rows, issues one load per granted row,
// tags each row with its quantization group index, and runs one K-pass per start.
module redmule_w_loader
    import redmule_pkg::*;
#(
    parameter int unsigned DW         = 288,
    parameter int unsigned H          = ARRAY_HEIGHT,
    parameter int unsigned GID_WIDTH  = GROUP_ID_WIDTH,
    parameter int unsigned CNT_W      = W_LOADER_CNT_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [CNT_W-1:0]             k_rows_i,
    input  logic [3:0]                   gsize_log2_i,
    input  logic                         dequant_i,
    input  logic [DW-1:0]                in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         grant_i,
    output logic [DW-1:0]                w_data_o,
    output logic                         load_o,
    output logic                         dequant_o,
    output logic [$clog2(GID_WIDTH)-1:0] next_gidx_o,
    output logic                         fill_wrap_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned GIDX_W = $clog2(GID_WIDTH);
    localparam int unsigned FILL_W = (H > 1) ? $clog2(H) : 1;

    w_loader_state_e r_state;
    logic [CNT_W-1:0]  r_kRows;
    logic [CNT_W-1:0]  r_rowCnt;
    logic [CNT_W-1:0]  r_acceptedCnt;
    logic [FILL_W-1:0] r_fillCnt;
    logic [3:0]        r_gsize;
    logic              r_dequant;
    logic [DW-1:0]     r_holdData;

    w_loader_ctrl_t    w_ctrl;
    logic              w_ready;
    logic              w_push;
    logic              w_load;
    logic              w_full;
    logic              w_empty;
    logic              w_lastRow;
    logic              w_fillLast;
    logic [DW-1:0]     w_head;
    logic [GIDX_W-1:0] w_gidx;

    assign w_ctrl = '{start: start_i, k_rows: k_rows_i, gsize_log2: gsize_log2_i, dequant: dequant_i};

    assign w_ready    = (r_state == RUN) && !w_full && (r_acceptedCnt != r_kRows);
    assign w_push     = in_valid_i && w_ready;
    assign w_load     = (r_state == RUN) && !w_empty && grant_i;
    assign w_lastRow  = (r_rowCnt == (r_kRows - CNT_W'(1)));
    assign w_fillLast = (r_fillCnt == FILL_W'(H - 1));
    assign w_gidx     = GIDX_W'(r_rowCnt >> r_gsize);

    assign in_ready_o  = w_ready;
    assign load_o      = w_load;
    assign w_data_o    = w_empty ? r_holdData : w_head;
    assign dequant_o   = r_dequant;
    assign next_gidx_o = r_dequant ? w_gidx : '0;
    assign fill_wrap_o = w_load && w_fillLast;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);

    redmule_w_loader_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_flush (clear_i),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_data  (in_data_i),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pass sequencing plus the accept, row and fill counters; clear wins over any start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_kRows       <= '0;
            r_rowCnt      <= '0;
            r_acceptedCnt <= '0;
            r_fillCnt     <= '0;
            r_gsize       <= '0;
            r_dequant     <= 1'b0;
        end else if (clear_i) begin
            r_state       <= IDLE;
            r_rowCnt      <= '0;
            r_acceptedCnt <= '0;
            r_fillCnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ctrl.start) begin
                        r_kRows       <= w_ctrl.k_rows;
                        r_gsize       <= w_ctrl.gsize_log2;
                        r_dequant     <= w_ctrl.dequant;
                        r_rowCnt      <= '0;
                        r_acceptedCnt <= '0;
                        r_fillCnt     <= '0;
                        r_state       <= (w_ctrl.k_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_push) r_acceptedCnt <= r_acceptedCnt + CNT_W'(1);
                    if (w_load) begin
                        r_rowCnt  <= r_rowCnt + CNT_W'(1);
                        r_fillCnt <= w_fillLast ? '0 : r_fillCnt + FILL_W'(1);
                        if (w_lastRow) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Remember the last loaded row so the W-buffer data lines stay put while the FIFO is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_holdData <= '0;
        end else if (w_load) begin
            r_holdData <= w_head;
        end
    end

endmodule

// File: tb/tb_redmule_w_loader.sv
// Directed bench for redmule_w_loader: streaming passes, backpressure,
// dequant group indices, empty passes, soft clear and async reset.
module tb_redmule_w_loader;

    localparam int DW     = 288;
    localparam int CNT_W  = 16;
    localparam int GIDX_W = 4;
    localparam int H      = 12;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              start_i = 1'b0;
    logic [CNT_W-1:0]  k_rows_i = '0;
    logic [3:0]        gsize_log2_i = '0;
    logic              dequant_i = 1'b0;
    logic [DW-1:0]     in_data_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic              grant_i = 1'b0;
    logic [DW-1:0]     w_data_o;
    logic              load_o;
    logic              dequant_o;
    logic [GIDX_W-1:0] next_gidx_o;
    logic              fill_wrap_o;
    logic              busy_o;
    logic              done_o;

    int nVec = 0;
    int nErr = 0;

    always #5 clk_i = ~clk_i;

    redmule_w_loader dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .k_rows_i     (k_rows_i),
        .gsize_log2_i (gsize_log2_i),
        .dequant_i    (dequant_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .grant_i      (grant_i),
        .w_data_o     (w_data_o),
        .load_o       (load_o),
        .dequant_o    (dequant_o),
        .next_gidx_o  (next_gidx_o),
        .fill_wrap_o  (fill_wrap_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    function automatic logic [DW-1:0] rowData(input int seed, input int idx);
        logic [31:0] w;
        w = 32'h5A00_0000 ^ (32'(seed) << 16) ^ 32'(idx);
        return {9{w}};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        grant_i = 1'b1;
        in_valid_i = 1'b1;
        #2;
        nVec++; if (in_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset in_ready: got %b want 0", in_ready_o); end
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset load: got %b want 0", load_o); end
        nVec++; if (w_data_o !== '0) begin nErr++; $display("[TB] FAIL reset w_data: got %h want 0", w_data_o); end
        nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset busy: got %b want 0", busy_o); end
        nVec++; if (done_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset done: got %b want 0", done_o); end
        nVec++; if (dequant_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset dequant: got %b want 0", dequant_o); end
        nVec++; if (next_gidx_o !== '0) begin nErr++; $display("[TB] FAIL reset gidx: got %0d want 0", next_gidx_o); end
        nVec++; if (fill_wrap_o !== 1'b0) begin nErr++; $display("[TB] FAIL reset fill_wrap: got %b want 0", fill_wrap_o); end
        in_valid_i = 1'b0;
        grant_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    // Full-rate pass: valid and grant held high; inputs scrambled after start to check sampling.
    task automatic test_stream(input string name, input int seed, input int k,
                               input logic [3:0] gs, input logic deq);
        int sent, loads;
        logic expReady, expLoad, expDone, expBusy, expWrap;
        logic [GIDX_W-1:0] expGidx;
        sent = 0;
        loads = 0;
        in_valid_i = 1'b0;
        grant_i = 1'b1;
        k_rows_i = CNT_W'(k);
        gsize_log2_i = gs;
        dequant_i = deq;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k_rows_i = '1;
        gsize_log2_i = 4'd0;
        dequant_i = ~deq;
        for (int cyc = 0; cyc <= k + 2; cyc++) begin
            in_valid_i = 1'b1;
            in_data_i = rowData(seed, sent);
            grant_i = 1'b1;
            #1;
            expReady = (cyc < k);
            expLoad  = (cyc >= 1) && (cyc <= k);
            expDone  = (cyc == k + 1);
            expBusy  = (cyc <= k + 1);
            expWrap  = expLoad && ((loads % H) == H - 1);
            expGidx  = deq ? GIDX_W'(loads >> gs) : '0;
            nVec++; if (in_ready_o !== expReady) begin nErr++; $display("[TB] FAIL %s in_ready cyc%0d: got %b want %b", name, cyc, in_ready_o, expReady); end
            nVec++; if (load_o !== expLoad) begin nErr++; $display("[TB] FAIL %s load cyc%0d: got %b want %b", name, cyc, load_o, expLoad); end
            nVec++; if (done_o !== expDone) begin nErr++; $display("[TB] FAIL %s done cyc%0d: got %b want %b", name, cyc, done_o, expDone); end
            nVec++; if (busy_o !== expBusy) begin nErr++; $display("[TB] FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy_o, expBusy); end
            nVec++; if (fill_wrap_o !== expWrap) begin nErr++; $display("[TB] FAIL %s fill_wrap cyc%0d: got %b want %b", name, cyc, fill_wrap_o, expWrap); end
            nVec++; if (dequant_o !== deq) begin nErr++; $display("[TB] FAIL %s dequant cyc%0d: got %b want %b", name, cyc, dequant_o, deq); end
            if (expLoad) begin
                nVec++; if (w_data_o !== rowData(seed, loads)) begin nErr++; $display("[TB] FAIL %s w_data row%0d: got %h want %h", name, loads, w_data_o[31:0], rowData(seed, loads)); end
                nVec++; if (next_gidx_o !== expGidx) begin nErr++; $display("[TB] FAIL %s gidx row%0d: got %0d want %0d", name, loads, next_gidx_o, expGidx); end
            end
            if (in_ready_o && in_valid_i) sent++;
            if (load_o) loads++;
            tick();
        end
        in_valid_i = 1'b0;
        nVec++; if (loads !== k) begin nErr++; $display("[TB] FAIL %s load count: got %0d want %0d", name, loads, k); end
        nVec++; if (sent !== k) begin nErr++; $display("[TB] FAIL %s accept count: got %0d want %0d", name, sent, k); end
    endtask

    // Grant withheld for five cycles: the FIFO fills after two accepts and nothing is lost.
    task automatic test_backpressure();
        int sent, loads;
        logic expReady, expLoad, expDone;
        sent = 0;
        loads = 0;
        grant_i = 1'b0;
        k_rows_i = CNT_W'(4);
        gsize_log2_i = 4'd0;
        dequant_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            in_valid_i = 1'b1;
            in_data_i = rowData(2, sent);
            grant_i = (cyc >= 5);
            #1;
            expReady = (cyc == 0) || (cyc == 1) || (cyc == 6) || (cyc == 7);
            expLoad  = (cyc >= 5) && (cyc <= 8);
            expDone  = (cyc == 9);
            nVec++; if (in_ready_o !== expReady) begin nErr++; $display("[TB] FAIL bp in_ready cyc%0d: got %b want %b", cyc, in_ready_o, expReady); end
            nVec++; if (load_o !== expLoad) begin nErr++; $display("[TB] FAIL bp load cyc%0d: got %b want %b", cyc, load_o, expLoad); end
            nVec++; if (done_o !== expDone) begin nErr++; $display("[TB] FAIL bp done cyc%0d: got %b want %b", cyc, done_o, expDone); end
            if (expLoad) begin
                nVec++; if (w_data_o !== rowData(2, loads)) begin nErr++; $display("[TB] FAIL bp w_data row%0d: got %h want %h", loads, w_data_o[31:0], rowData(2, loads)); end
            end
            if (in_ready_o && in_valid_i) sent++;
            if (load_o) loads++;
            tick();
        end
        in_valid_i = 1'b0;
        nVec++; if (loads !== 4) begin nErr++; $display("[TB] FAIL bp load count: got %0d want 4", loads); end
    endtask

    // A zero-row pass goes straight to DONE without ever opening the stream.
    task automatic test_zero_rows();
        in_valid_i = 1'b1;
        in_data_i = rowData(4, 0);
        grant_i = 1'b1;
        k_rows_i = '0;
        dequant_i = 1'b0;
        start_i = 1'b1;
        #1;
        nVec++; if (in_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero idle in_ready: got %b want 0", in_ready_o); end
        tick();
        start_i = 1'b0;
        #1;
        nVec++; if (busy_o !== 1'b1) begin nErr++; $display("[TB] FAIL zero busy: got %b want 1", busy_o); end
        nVec++; if (done_o !== 1'b1) begin nErr++; $display("[TB] FAIL zero done: got %b want 1", done_o); end
        nVec++; if (in_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero in_ready: got %b want 0", in_ready_o); end
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero load: got %b want 0", load_o); end
        tick();
        #1;
        nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero busy after: got %b want 0", busy_o); end
        nVec++; if (done_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero done after: got %b want 0", done_o); end
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL zero load after: got %b want 0", load_o); end
        in_valid_i = 1'b0;
        tick();
    endtask

    // Clear after three loads with two rows buffered, then a short pass must start clean.
    task automatic test_clear();
        int sent, loads;
        logic expLoad, expReady;
        sent = 0;
        loads = 0;
        k_rows_i = CNT_W'(8);
        gsize_log2_i = 4'd0;
        dequant_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            in_valid_i = 1'b1;
            in_data_i = rowData(5, sent);
            grant_i = (cyc <= 3);
            #1;
            expLoad  = (cyc >= 1) && (cyc <= 3);
            expReady = 1'b1;
            nVec++; if (load_o !== expLoad) begin nErr++; $display("[TB] FAIL clr load cyc%0d: got %b want %b", cyc, load_o, expLoad); end
            nVec++; if (in_ready_o !== expReady) begin nErr++; $display("[TB] FAIL clr in_ready cyc%0d: got %b want %b", cyc, in_ready_o, expReady); end
            if (expLoad) begin
                nVec++; if (w_data_o !== rowData(5, loads)) begin nErr++; $display("[TB] FAIL clr w_data row%0d: got %h want %h", loads, w_data_o[31:0], rowData(5, loads)); end
            end
            if (in_ready_o && in_valid_i) sent++;
            if (load_o) loads++;
            tick();
        end
        grant_i = 1'b0;
        clear_i = 1'b1;
        #1;
        nVec++; if (in_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr full in_ready: got %b want 0", in_ready_o); end
        tick();
        start_i = 1'b1;
        k_rows_i = CNT_W'(3);
        grant_i = 1'b1;
        #1;
        nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr busy: got %b want 0", busy_o); end
        nVec++; if (done_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr done: got %b want 0", done_o); end
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr load: got %b want 0", load_o); end
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        #1;
        nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr start ignored busy: got %b want 0", busy_o); end
        nVec++; if (done_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr no done: got %b want 0", done_o); end
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL clr fifo empty load: got %b want 0", load_o); end
        in_valid_i = 1'b0;
        tick();
        test_stream("t5 restart", 6, 2, 4'd0, 1'b1);
    endtask

    // Reset asserted mid-pass must zero every output without waiting for a clock edge.
    task automatic test_async_reset();
        int sent;
        sent = 0;
        k_rows_i = CNT_W'(12);
        gsize_log2_i = 4'd1;
        dequant_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid_i = 1'b1;
            in_data_i = rowData(8, sent);
            grant_i = 1'b1;
            #1;
            if (in_ready_o) sent++;
            tick();
        end
        in_valid_i = 1'b1;
        grant_i = 1'b1;
        #1;
        nVec++; if (load_o !== 1'b1) begin nErr++; $display("[TB] FAIL arst pre load: got %b want 1", load_o); end
        rst_ni = 1'b0;
        #1;
        nVec++; if (load_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst load: got %b want 0", load_o); end
        nVec++; if (in_ready_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst in_ready: got %b want 0", in_ready_o); end
        nVec++; if (w_data_o !== '0) begin nErr++; $display("[TB] FAIL arst w_data: got %h want 0", w_data_o[31:0]); end
        nVec++; if (busy_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst busy: got %b want 0", busy_o); end
        nVec++; if (done_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst done: got %b want 0", done_o); end
        nVec++; if (dequant_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst dequant: got %b want 0", dequant_o); end
        nVec++; if (next_gidx_o !== '0) begin nErr++; $display("[TB] FAIL arst gidx: got %0d want 0", next_gidx_o); end
        nVec++; if (fill_wrap_o !== 1'b0) begin nErr++; $display("[TB] FAIL arst fill_wrap: got %b want 0", fill_wrap_o); end
        in_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        test_stream("t6 after reset", 7, 12, 4'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream("t1 stream", 1, 12, 4'd0, 1'b0);
        test_backpressure();
        test_stream("t3 dequant", 3, 10, 4'd2, 1'b1);
        test_zero_rows();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
